// File: rtl/pu_feeder.sv
// Operand sequencer for one 4-input processing unit: streams records from operand memory
// onto the PU operand ports, tracks PU latency and captures each result with its index.
module pu_feeder #(
    parameter int DW     = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int PU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [8*DW-1:0]   rd_data,
    output logic [DW-1:0]     a1,
    output logic [DW-1:0]     a2,
    output logic [DW-1:0]     a3,
    output logic [DW-1:0]     a4,
    output logic [DW-1:0]     w1,
    output logic [DW-1:0]     w2,
    output logic [DW-1:0]     w3,
    output logic [DW-1:0]     w4,
    input  logic [DW-1:0]     pu_out,
    output logic              res_valid,
    output logic [CNT_W-1:0]  res_idx,
    output logic [DW-1:0]     res_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]              state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        rd_cnt_r;
    logic [CNT_W-1:0]        res_cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    rd_en_r;
    logic [ADDR_W-1:0]       rd_addr_r;
    logic                    rd_vld_r;
    logic [PU_LAT:0]         vld_pipe_r;
    logic [7:0][DW-1:0]      op_r;
    logic                    res_valid_r;
    logic [CNT_W-1:0]        res_idx_r;
    logic [DW-1:0]           res_data_r;

    logic                    start_ok_s;
    logic                    count_zero_s;
    logic                    cap_s;
    logic                    last_cap_s;

    // Start is only honoured once busy has dropped, so a start in the done cycle is ignored.
    always_comb begin
        start_ok_s   = start && (state_r == S_IDLE) && !busy_r;
        count_zero_s = (count == {CNT_W{1'b0}});
        cap_s        = vld_pipe_r[PU_LAT];
        last_cap_s   = cap_s && (res_cnt_r == (cnt_r - CNT_W'(1)));
    end

    // Run FSM and operand-memory read sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rd_cnt_r  <= {CNT_W{1'b0}};
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_ok_s && !count_zero_s) begin
                        state_r   <= S_ISSUE;
                        cnt_r     <= count;
                        rd_cnt_r  <= CNT_W'(1);
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= base_addr;
                    end
                end
                S_ISSUE: begin
                    if (rd_cnt_r == cnt_r) begin
                        rd_en_r <= 1'b0;
                        state_r <= S_DRAIN;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                        rd_cnt_r  <= rd_cnt_r + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (last_cap_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Busy spans the first read through the final result; done pulses with the final result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (start_ok_s && count_zero_s) || last_cap_s;
            if (start_ok_s && !count_zero_s) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Operand registers and the valid bit that follows each record through the PU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r   <= 1'b0;
            vld_pipe_r <= {(PU_LAT+1){1'b0}};
            op_r       <= {(8*DW){1'b0}};
        end else begin
            rd_vld_r   <= rd_en_r;
            vld_pipe_r <= {vld_pipe_r[PU_LAT-1:0], rd_vld_r};
            if (rd_vld_r) begin
                op_r <= rd_data;
            end
        end
    end

    // Result capture; res_data and res_idx hold their last values between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_idx_r   <= {CNT_W{1'b0}};
            res_data_r  <= {DW{1'b0}};
            res_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            res_valid_r <= cap_s;
            if (start_ok_s) begin
                res_cnt_r <= {CNT_W{1'b0}};
            end else if (cap_s) begin
                res_cnt_r <= res_cnt_r + CNT_W'(1);
            end
            if (cap_s) begin
                res_data_r <= pu_out;
                res_idx_r  <= res_cnt_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign a1        = op_r[0];
    assign a2        = op_r[1];
    assign a3        = op_r[2];
    assign a4        = op_r[3];
    assign w1        = op_r[4];
    assign w2        = op_r[5];
    assign w3        = op_r[6];
    assign w4        = op_r[7];
    assign res_valid = res_valid_r;
    assign res_idx   = res_idx_r;
    assign res_data  = res_data_r;

endmodule

// File: tb/tb_pu_feeder.sv
// Bench for pu_feeder: PU stub delays a1 by PU_LAT edges, memory a1 field is 100+addr;
// per-cycle expectations come from the run timeline (reads c1..cN, results from c(4+PU_LAT)).
module tb_pu_feeder;

    localparam int DW     = 32;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;
    localparam int PU_LAT = 2;
    localparam int FIRST  = 4 + PU_LAT;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              busy, done, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [8*DW-1:0]   rd_data;
    logic [DW-1:0]     a1, a2, a3, a4, w1, w2, w3, w4;
    logic [DW-1:0]     pu_out;
    logic              res_valid;
    logic [CNT_W-1:0]  res_idx;
    logic [DW-1:0]     res_data;
    logic [DW-1:0]     d1, d2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem_seed;

    always #5 clk = ~clk;

    pu_feeder #(.DW(DW), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PU_LAT(PU_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .pu_out(pu_out), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    function automatic logic [31:0] field(input int addr, input int k);
        if (k == 0) return 32'(100 + addr);
        return mem_seed ^ 32'(k << 20) ^ 32'(addr * 7919);
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            for (int k = 0; k < 8; k++) rd_data[DW*k +: DW] <= field(int'(rd_addr), k);
        end
    end

    always @(posedge clk) begin
        d1 <= a1;
        d2 <= d1;
    end
    assign pu_out = d2;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One run: start in c0, check every output in c1..cncyc; inj>0 pulses a stray start.
    task automatic run(input int base, input int n, input int inj, input int ncyc);
        logic [31:0] got [8];
        logic        e_en, e_rv, e_done, e_busy;
        int          eaddr;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'(base); count = 8'(n);
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == inj);
            base_addr = 8'($urandom);
            count = 8'($urandom_range(1, 255));
            @(negedge clk);
            e_en   = (n > 0) && (cyc <= n);
            e_rv   = (n > 0) && (cyc >= FIRST) && (cyc < FIRST + n);
            e_done = (n > 0) ? (cyc == FIRST + n - 1) : (cyc == 1);
            e_busy = (n > 0) && (cyc <= FIRST + n - 1);
            n_cmp++;
            if (rd_en !== e_en) begin
                n_bad++; $display("FAIL rd_en base=%0d n=%0d c%0d: got %b want %b", base, n, cyc, rd_en, e_en);
            end
            if (e_en) begin
                n_cmp++;
                if (rd_addr !== 8'(base + cyc - 1)) begin
                    n_bad++; $display("FAIL rd_addr c%0d: got %0d want %0d", cyc, rd_addr, 8'(base + cyc - 1));
                end
            end
            n_cmp++;
            if (res_valid !== e_rv) begin
                n_bad++; $display("FAIL res_valid base=%0d n=%0d c%0d: got %b want %b", base, n, cyc, res_valid, e_rv);
            end
            if (e_rv) begin
                n_cmp++;
                if (res_idx !== 8'(cyc - FIRST)) begin
                    n_bad++; $display("FAIL res_idx c%0d: got %0d want %0d", cyc, res_idx, cyc - FIRST);
                end
            end
            if ((n > 0) && (cyc >= FIRST)) begin
                eaddr = (base + imin(cyc - FIRST, n - 1)) & 255;
                n_cmp++;
                if (res_data !== 32'(100 + eaddr)) begin
                    n_bad++; $display("FAIL res_data c%0d: got %0d want %0d", cyc, res_data, 100 + eaddr);
                end
            end
            n_cmp++;
            if (done !== e_done) begin
                n_bad++; $display("FAIL done base=%0d n=%0d c%0d: got %b want %b", base, n, cyc, done, e_done);
            end
            n_cmp++;
            if (busy !== e_busy) begin
                n_bad++; $display("FAIL busy base=%0d n=%0d c%0d: got %b want %b", base, n, cyc, busy, e_busy);
            end
            if ((n > 0) && (cyc >= 3)) begin
                eaddr = (base + imin(cyc - 3, n - 1)) & 255;
                got = '{a1, a2, a3, a4, w1, w2, w3, w4};
                for (int k = 0; k < 8; k++) begin
                    n_cmp++;
                    if (got[k] !== field(eaddr, k)) begin
                        n_bad++; $display("FAIL operand%0d c%0d: got %h want %h", k, cyc, got[k], field(eaddr, k));
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, rd_en, rd_addr, res_valid, res_idx, res_data, a1, a2, a3, a4, w1, w2, w3, w4} !== '0) begin
            n_bad++; $display("FAIL reset_state: got busy=%b done=%b rd_en=%b res_valid=%b res_data=%h a1=%h want all 0",
                              busy, done, rd_en, res_valid, res_data, a1);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single();       run(0, 1, 0, 10);    endtask
    task automatic test_multi();        run(10, 4, 0, 13);   endtask
    task automatic test_wrap();         run(254, 4, 0, 13);  endtask
    task automatic test_start_busy();   run(30, 4, 3, 13);   endtask
    task automatic test_zero();         run(77, 0, 0, 6);    endtask

    task automatic test_back_to_back();
        run(5, 3, 0, FIRST + 3 - 1);
        run(40, 2, 0, FIRST + 2 - 1);
        run(200, 5, 0, 14);
    endtask

    task automatic test_reset_midrun();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd50; count = 8'd8;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, rd_en, rd_addr, res_valid, res_idx, res_data, a1, a2, a3, a4, w1, w2, w3, w4} !== '0) begin
            n_bad++; $display("FAIL midrun_reset: got busy=%b rd_en=%b rd_addr=%0d a1=%h want all 0", busy, rd_en, rd_addr, a1);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, rd_en, res_valid} !== 4'b0000) begin
                n_bad++; $display("FAIL after_reset c%0d: got busy=%b done=%b rd_en=%b res_valid=%b want 0",
                                  cyc, busy, done, rd_en, res_valid);
            end
        end
        run(20, 3, 0, 12);
    endtask

    task automatic test_random();
        int n, base, inj, b2b;
        for (int r = 0; r < 14; r++) begin
            n    = $urandom_range(0, 20);
            base = $urandom_range(0, 255);
            inj  = (n > 0) ? $urandom_range(0, FIRST + n - 1) : 0;
            b2b  = (n > 0) ? $urandom_range(0, 1) : 0;
            run(base, n, inj, (b2b != 0) ? (FIRST + n - 1) : (n + 9));
        end
    endtask

    initial begin
        mem_seed = $urandom;
        test_reset();
        test_single();
        test_multi();
        test_wrap();
        test_start_busy();
        test_zero();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
